// File: rtl/fc_burst_reader.sv
// fc_burst_reader: multi-channel burst read engine for the FC datapath.
// On start, fetches word_cnt[c] words for each channel c from base_addr[c]
// as bursts of up to MAX_LEN beats. Channels are serviced round-robin, and
// returned beats are steered to one-hot per-channel strobes.
//
// State table:
//   IDLE | waiting for start; bases and counts latched on an accepted start
//   ARB  | pick the next channel with remaining words, register burst fields
//   ADDR | arvalid high; burst fields held until arready
//   DATA | rready high; forward matching beats until the burst closes
//   DONE | one-cycle done pulse
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job start (sampled in IDLE only)
//   base_addr, word_cnt   packed per-channel bases / word counts
//   busy, done, err       job status; err is sticky until the next start
//   araddr, arlen, arvalid, aruser_id, aruser_ap, arready   read-address channel
//   rvalid, rlast, rid, rdata, rready                        read-data channel
//   out_data, out_valid, out_last                           per-channel beat output
module fc_burst_reader #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 28,
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 16,
  parameter int MAX_LEN = 16,
  parameter int ID_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH*CNT_W-1:0]  word_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        araddr,
  output logic [3:0]               arlen,
  output logic                     arvalid,
  output logic [ID_W-1:0]          aruser_id,
  output logic                     aruser_ap,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic                     rlast,
  input  logic [ID_W-1:0]          rid,
  input  logic [WIDTH-1:0]         rdata,
  output logic                     rready,
  output logic [WIDTH-1:0]         out_data,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH-1:0]        out_last
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W = 5;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(WIDTH / 8);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [CNT_W-1:0]  rem_q  [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cur_ch;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  got_q;

  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic [CNT_W-1:0]  sel_rem;
  logic [LEN_W-1:0]  sel_len;
  int                srch_idx;

  logic              beat_ok;
  logic              beat_bad;
  logic [LEN_W-1:0]  got_inc;
  logic              len_hit;
  logic [CH_W-1:0]   next_ptr;
  logic [NUM_CH-1:0] cur_onehot;

  assign arvalid = (state == S_ADDR);
  assign rready  = (state == S_DATA);
  assign done    = (state == S_DONE);
  assign busy    = (state == S_ARB) || (state == S_ADDR) || (state == S_DATA);

  // Round-robin search starting at rr_ptr, wrapping at NUM_CH.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    srch_idx  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      srch_idx = int'(rr_ptr) + i;
      if (srch_idx >= NUM_CH) srch_idx = srch_idx - NUM_CH;
      if (!sel_found && rem_q[srch_idx] != '0) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(srch_idx);
      end
    end
  end

  always_comb begin
    sel_rem = rem_q[sel_ch];
    if (sel_rem >= CNT_W'(MAX_LEN)) sel_len = LEN_W'(MAX_LEN);
    else                            sel_len = LEN_W'(sel_rem);
  end

  assign beat_ok    = (state == S_DATA) && rvalid && (rid == ID_W'(cur_ch));
  assign beat_bad   = (state == S_DATA) && rvalid && (rid != ID_W'(cur_ch));
  assign got_inc    = got_q + LEN_W'(1);
  assign len_hit    = (got_inc == len_q);
  assign next_ptr   = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
  assign cur_onehot = NUM_CH'(1) << cur_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_q[c] <= '0;
        rem_q[c]  <= '0;
      end
      rr_ptr    <= '0;
      cur_ch    <= '0;
      len_q     <= '0;
      got_q     <= '0;
      err       <= 1'b0;
      araddr    <= '0;
      arlen     <= '0;
      aruser_id <= '0;
      aruser_ap <= 1'b0;
      out_data  <= '0;
      out_valid <= '0;
      out_last  <= '0;
    end else begin
      out_valid <= '0;
      out_last  <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int c = 0; c < NUM_CH; c++) begin
              addr_q[c] <= base_addr[c*ADDR_W +: ADDR_W];
              rem_q[c]  <= word_cnt[c*CNT_W +: CNT_W];
            end
            err    <= 1'b0;
            rr_ptr <= '0;
            state  <= S_ARB;
          end
        end
        S_ARB: begin
          if (!sel_found) begin
            state <= S_DONE;
          end else begin
            cur_ch    <= sel_ch;
            len_q     <= sel_len;
            got_q     <= '0;
            araddr    <= addr_q[sel_ch];
            arlen     <= 4'(sel_len - LEN_W'(1));
            aruser_id <= ID_W'(sel_ch);
            aruser_ap <= (sel_rem == CNT_W'(sel_len));
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) state <= S_DATA;
        end
        S_DATA: begin
          if (beat_bad) err <= 1'b1;
          if (beat_ok) begin
            out_data  <= rdata;
            out_valid <= cur_onehot;
            if (rem_q[cur_ch] == CNT_W'(1)) out_last <= cur_onehot;
            got_q          <= got_inc;
            rem_q[cur_ch]  <= rem_q[cur_ch] - CNT_W'(1);
            addr_q[cur_ch] <= addr_q[cur_ch] + BEAT_BYTES;
            // rlast must coincide with the final expected beat; a mismatch
            // either way is a framing error. Short bursts leave words in
            // rem_q so a later burst re-requests them.
            if (rlast != len_hit) err <= 1'b1;
            if (rlast || len_hit) begin
              rr_ptr <= next_ptr;
              state  <= S_ARB;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
